video_mode_switch_ctrl: RTL and testbench

VIDEO_MODE_SWITCH_CTRL -- requirements
Module: video_mode_switch_ctrl

---
 rtl/video_timing_pkg.sv | 27 ++
 rtl/video_mode_switch_ctrl_vs_edge_det.sv | 22 ++
 rtl/video_mode_switch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_video_mode_switch_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// Shared video timing definitions: mode codes, default mode width and the
// state encoding of the mode-switch controller.
package video_timing_pkg;

    localparam int VT_MODE_W = 3;

    localparam int unsigned MODE_1080P60 = 0;
    localparam int unsigned MODE_720P60  = 1;
    localparam int unsigned MODE_1080I60 = 2;
    localparam int unsigned MODE_576P50  = 3;
    localparam int unsigned MODE_480P60  = 4;

    typedef enum logic [2:0] {
        ST_STOPPED,
        ST_RUN,
        ST_WAIT_VS,
        ST_SETTLE,
        ST_LOAD,
        ST_RESTART
    } vms_state_e;

    // States in which the controller is waiting on a vsync rise.
    function automatic logic is_vs_wait(input vms_state_e s);
        return (s == ST_WAIT_VS) || (s == ST_RESTART);
    endfunction

endpackage

// File: rtl/video_mode_switch_ctrl_vs_edge_det.sv
// Vertical sync rise detector: one delay flop, rise = vs high while the
// delayed copy is still low. vs is assumed synchronous to the clock.
module vs_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vs_i,
    output logic rise_o
);

    logic vs_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_i;
        end
    end

    assign rise_o = vs_i & ~vs_q;

endmodule

// File: rtl/video_mode_switch_ctrl.sv
// Glitch-free video mode switch controller: stops the generator on vsync,
// settles, loads the new mode and restarts. Optional vsync timeout is
// enabled by defining VIDEO_MODE_SWITCH_TIMEOUT_EN.
module video_mode_switch_ctrl
    import video_timing_pkg::*;
#(
    parameter int          MODE_W         = VT_MODE_W,
    parameter int unsigned DEFAULT_MODE   = MODE_1080P60,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2500000
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              run,
    input  logic              req_valid,
    input  logic [MODE_W-1:0] req_mode,
    output logic              req_ready,
    input  logic              vs_in,
    output logic              gen_enable,
    output logic [MODE_W-1:0] gen_mode_sel,
    output logic              busy,
    output logic              switch_done,
    output logic              locked,
    output logic              timeout_err
);

    localparam logic [MODE_W-1:0] ResetMode  = MODE_W'(DEFAULT_MODE);
    localparam logic [15:0]       SettleLast = 16'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("video_mode_switch_ctrl: SETTLE_CYCLES or TIMEOUT_CYCLES out of range");
    end

    vms_state_e        state_q;
    logic [MODE_W-1:0] pending_q;
    logic [MODE_W-1:0] gen_mode_sel_q;
    logic [15:0]       settle_cnt_q;
    logic              gen_enable_q;
    logic              req_ready_q;
    logic              busy_q;
    logic              switch_done_q;
    logic              locked_q;
    logic              vs_rise;
    logic              to_hit;
    logic              xfer;

    vs_edge_det u_vs_edge_det (
        .clk_i  (pclk),
        .rst_i  (rst),
        .vs_i   (vs_in),
        .rise_o (vs_rise)
    );

    assign xfer = req_valid & req_ready_q;

    // Dropping run wins over everything, including a same-cycle request.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_STOPPED;
            pending_q      <= ResetMode;
            gen_mode_sel_q <= ResetMode;
            settle_cnt_q   <= '0;
            gen_enable_q   <= 1'b0;
            req_ready_q    <= 1'b0;
            busy_q         <= 1'b0;
            switch_done_q  <= 1'b0;
            locked_q       <= 1'b0;
        end else begin
            switch_done_q <= 1'b0;
            if (!run) begin
                state_q        <= ST_STOPPED;
                gen_enable_q   <= 1'b0;
                locked_q       <= 1'b0;
                req_ready_q    <= 1'b0;
                busy_q         <= 1'b0;
                gen_mode_sel_q <= pending_q;
            end else begin
                unique case (state_q)
                    ST_STOPPED: begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                    end
                    ST_RUN: begin
                        if (xfer) begin
                            if (req_mode != gen_mode_sel_q) begin
                                pending_q   <= req_mode;
                                state_q     <= ST_WAIT_VS;
                                req_ready_q <= 1'b0;
                                busy_q      <= 1'b1;
                            end else begin
                                switch_done_q <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_VS: begin
                        if (vs_rise || to_hit) begin
                            state_q      <= ST_SETTLE;
                            gen_enable_q <= 1'b0;
                            settle_cnt_q <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        // New mode is presented while the generator is still off.
                        if (settle_cnt_q == SettleLast) begin
                            state_q        <= ST_LOAD;
                            gen_mode_sel_q <= pending_q;
                        end else if (settle_cnt_q != 16'hFFFF) begin
                            settle_cnt_q <= settle_cnt_q + 16'd1;
                        end
                    end
                    ST_LOAD: begin
                        state_q      <= ST_RESTART;
                        gen_enable_q <= 1'b1;
                        locked_q     <= 1'b0;
                    end
                    ST_RESTART: begin
                        if (vs_rise || to_hit) begin
                            state_q       <= ST_RUN;
                            locked_q      <= 1'b1;
                            switch_done_q <= 1'b1;
                            req_ready_q   <= 1'b1;
                            busy_q        <= 1'b0;
                        end
                    end
                    default: begin
                        state_q      <= ST_STOPPED;
                        gen_enable_q <= 1'b0;
                        busy_q       <= 1'b0;
                        req_ready_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef VIDEO_MODE_SWITCH_TIMEOUT_EN
    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] to_cnt_q;
    logic [31:0] to_cnt_d;
    logic        timeout_err_q;

    assign to_hit = is_vs_wait(state_q) && (to_cnt_q == TimeoutLast);

    // Counter is held at zero outside the vsync waits, so every wait starts fresh.
    always_comb begin
        to_cnt_d = '0;
        if (run && is_vs_wait(state_q) && !vs_rise && !to_hit) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if (run && to_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign req_ready    = req_ready_q;
    assign gen_enable   = gen_enable_q;
    assign gen_mode_sel = gen_mode_sel_q;
    assign busy         = busy_q;
    assign switch_done  = switch_done_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_video_mode_switch_ctrl.sv
// Directed bench for video_mode_switch_ctrl with SETTLE_CYCLES=4 and
// TIMEOUT_CYCLES=100; covers both builds of VIDEO_MODE_SWITCH_TIMEOUT_EN.
module tb_video_mode_switch_ctrl;
    import video_timing_pkg::*;

    logic       pclk;
    logic       rst;
    logic       run;
    logic       req_valid;
    logic [2:0] req_mode;
    logic       req_ready;
    logic       vs_in;
    logic       gen_enable;
    logic [2:0] gen_mode_sel;
    logic       busy;
    logic       switch_done;
    logic       locked;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    video_mode_switch_ctrl #(
        .MODE_W         (3),
        .DEFAULT_MODE   (MODE_1080P60),
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .pclk         (pclk),
        .rst          (rst),
        .run          (run),
        .req_valid    (req_valid),
        .req_mode     (req_mode),
        .req_ready    (req_ready),
        .vs_in        (vs_in),
        .gen_enable   (gen_enable),
        .gen_mode_sel (gen_mode_sel),
        .busy         (busy),
        .switch_done  (switch_done),
        .locked       (locked),
        .timeout_err  (timeout_err)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
    task automatic applyStimulus(input bit r, input bit v, input bit [2:0] m, input bit vs);
        run       = r;
        req_valid = v;
        req_mode  = m;
        vs_in     = vs;
        @(posedge pclk);
        #1;
    endtask

    // Called right after the edge that entered SETTLE.
    task automatic settleAndLoad(input logic [2:0] expMode);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            checkOutput("settle_en_low", 32'(gen_enable), 0);
        end
        checkOutput("load_mode", 32'(gen_mode_sel), 32'(expMode));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("restart_en_high", 32'(gen_enable), 1);
        checkOutput("restart_unlocked", 32'(locked), 0);
        checkOutput("restart_busy", 32'(busy), 1);
        checkOutput("restart_mode", 32'(gen_mode_sel), 32'(expMode));
    endtask

    task automatic lockOnRise();
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        checkOutput("lock_locked", 32'(locked), 1);
        checkOutput("lock_done", 32'(switch_done), 1);
        checkOutput("lock_ready", 32'(req_ready), 1);
        checkOutput("lock_busy", 32'(busy), 0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("done_pulse_end", 32'(switch_done), 0);
        checkOutput("run_locked", 32'(locked), 1);
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        req_valid = 1'b0;
        req_mode  = 3'd0;
        vs_in     = 1'b0;
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("rst_enable", 32'(gen_enable), 0);
        checkOutput("rst_mode", 32'(gen_mode_sel), 0);
        checkOutput("rst_ready", 32'(req_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(switch_done), 0);
        checkOutput("rst_locked", 32'(locked), 0);
        checkOutput("rst_timeout", 32'(timeout_err), 0);
        rst = 1'b0;

        $display("[TB] startup from STOPPED");
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("start_en", 32'(gen_enable), 0);
        settleAndLoad(3'(MODE_1080P60));
        lockOnRise();

        $display("[TB] same-mode request");
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        checkOutput("same_done", 32'(switch_done), 1);
        checkOutput("same_en", 32'(gen_enable), 1);
        checkOutput("same_ready", 32'(req_ready), 1);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("same_done_end", 32'(switch_done), 0);
        checkOutput("same_en_hold", 32'(gen_enable), 1);

        $display("[TB] switch to 1080i60");
        applyStimulus(1'b1, 1'b1, 3'(MODE_1080I60), 1'b0);
        checkOutput("acc_busy", 32'(busy), 1);
        checkOutput("acc_ready", 32'(req_ready), 0);
        checkOutput("acc_en", 32'(gen_enable), 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            checkOutput("wait_en_high", 32'(gen_enable), 1);
        end
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        checkOutput("rise_en_drop", 32'(gen_enable), 0);
        checkOutput("rise_mode_old", 32'(gen_mode_sel), 0);
        settleAndLoad(3'(MODE_1080I60));
        lockOnRise();

        $display("[TB] run drop during SETTLE");
        applyStimulus(1'b1, 1'b1, 3'(MODE_576P50), 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("stop_en", 32'(gen_enable), 0);
        checkOutput("stop_locked", 32'(locked), 0);
        checkOutput("stop_mode", 32'(gen_mode_sel), 32'(MODE_576P50));
        checkOutput("stop_busy", 32'(busy), 0);
        checkOutput("stop_ready", 32'(req_ready), 0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("stop_en_hold", 32'(gen_enable), 0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        settleAndLoad(3'(MODE_576P50));
        lockOnRise();

        $display("[TB] run drop with simultaneous request");
        applyStimulus(1'b0, 1'b1, 3'd5, 1'b0);
        checkOutput("prio_ready", 32'(req_ready), 0);
        checkOutput("prio_en", 32'(gen_enable), 0);
        checkOutput("prio_mode", 32'(gen_mode_sel), 32'(MODE_576P50));
        checkOutput("prio_done", 32'(switch_done), 0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        settleAndLoad(3'(MODE_576P50));
        lockOnRise();

        $display("[TB] vsync absent after request");
        applyStimulus(1'b1, 1'b1, 3'(MODE_720P60), 1'b0);
`ifdef VIDEO_MODE_SWITCH_TIMEOUT_EN
        for (int i = 1; i <= 99; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        end
        checkOutput("pre_timeout_err", 32'(timeout_err), 0);
        checkOutput("pre_timeout_en", 32'(gen_enable), 1);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("timeout_err_set", 32'(timeout_err), 1);
        checkOutput("timeout_en_drop", 32'(gen_enable), 0);
`else
        for (int i = 0; i < 150; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        end
        checkOutput("park_busy", 32'(busy), 1);
        checkOutput("park_en", 32'(gen_enable), 1);
        checkOutput("park_ready", 32'(req_ready), 0);
        checkOutput("park_err", 32'(timeout_err), 0);
        checkOutput("park_mode", 32'(gen_mode_sel), 32'(MODE_576P50));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        checkOutput("park_rise_en", 32'(gen_enable), 0);
`endif
        settleAndLoad(3'(MODE_720P60));
        lockOnRise();
`ifdef VIDEO_MODE_SWITCH_TIMEOUT_EN
        checkOutput("timeout_sticky", 32'(timeout_err), 1);
`else
        checkOutput("timeout_tied", 32'(timeout_err), 0);
`endif

        $display("[TB] reset during LOAD");
        applyStimulus(1'b1, 1'b1, 3'(MODE_1080I60), 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        end
        checkOutput("load_pre_rst_mode", 32'(gen_mode_sel), 32'(MODE_1080I60));
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_mode", 32'(gen_mode_sel), 0);
        checkOutput("mid_rst_en", 32'(gen_enable), 0);
        checkOutput("mid_rst_busy", 32'(busy), 0);
        checkOutput("mid_rst_ready", 32'(req_ready), 0);
        checkOutput("mid_rst_locked", 32'(locked), 0);
        checkOutput("mid_rst_done", 32'(switch_done), 0);
        checkOutput("mid_rst_err", 32'(timeout_err), 0);
        #2;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        settleAndLoad(3'(MODE_1080P60));
        lockOnRise();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
